bennett_clock: RTL and testbench

- Multi-phase Bennett-clock sequencer for the adiabatic processor.
- Produces PHASES staircase power-clock phases: phases rise in order 0..PHASES-1, hold, then fall in reverse order.
- Also produces a mid-plateau marker clock Mclk and an instruction-boundary flag instFlag.
- Downstream logic (SRAM bank clocking, pipeline stages) derives its timing from these outputs. Example: SRAM clock srclkneg = clkp[6] & ~Mclk.

---
 rtl/bennett_clock_if.sv | 30 +++
 rtl/bennett_clock.sv | 92 +++++++++
 tb/tb_bennett_clock.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bennett_clock_if.sv
// Bundle for the Bennett-clock sequencer outputs (and the optional hold input).
// The hold signal exists only when BENNETT_HOLD_EN is defined.
interface bennett_clock_if #(
  parameter int PHASES = 10
);
  logic [PHASES-1:0] clkp;
  logic              Mclk;
  logic              instFlag;
`ifdef BENNETT_HOLD_EN
  logic              hold;
`endif

  modport master (
`ifdef BENNETT_HOLD_EN
    input  hold,
`endif
    output clkp,
    output Mclk,
    output instFlag
  );

  modport slave (
`ifdef BENNETT_HOLD_EN
    output hold,
`endif
    input  clkp,
    input  Mclk,
    input  instFlag
  );
endinterface

// File: rtl/bennett_clock.sv
// Multi-phase Bennett staircase sequencer: phases rise 0..PHASES-1, hold, then fall in reverse.
// Optional macro BENNETT_HOLD_EN adds a hold input that freezes the top plateau.
module bennett_clock #(
  parameter int PHASES      = 10,
  parameter int STEP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  bennett_clock_if.master  bus
);
  localparam int SW = $clog2(2 * PHASES);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [SW-1:0] LAST_STEP = SW'(2 * PHASES - 1);
  localparam logic [SW-1:0] TOP_STEP  = SW'(PHASES - 1);
  localparam logic [CW-1:0] LAST_SUB  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] MID_SUB   = CW'(STEP_CYCLES / 2);

  if (PHASES < 2 || PHASES > 32) begin : gBadPhases
    $error("bennett_clock: PHASES must be in 2..32");
  end
  if (STEP_CYCLES < 2 || (STEP_CYCLES % 2) != 0) begin : gBadStep
    $error("bennett_clock: STEP_CYCLES must be even and >= 2");
  end

  logic [SW-1:0]     sReg, sNext;
  logic [CW-1:0]     cReg, cNext;
  logic [PHASES-1:0] clkpReg, clkpNext;
  logic              mclkReg, mclkNext;
  logic              instReg, instNext;
  logic              freeze;

`ifdef BENNETT_HOLD_EN
  assign freeze = bus.hold && (sReg == TOP_STEP);
`else
  assign freeze = 1'b0;
`endif

  // State register; outputs are registered alongside so they change only on edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sReg    <= LAST_STEP;
      cReg    <= LAST_SUB;
      clkpReg <= '0;
      mclkReg <= 1'b0;
      instReg <= 1'b0;
    end else begin
      sReg    <= sNext;
      cReg    <= cNext;
      clkpReg <= clkpNext;
      mclkReg <= mclkNext;
      instReg <= instNext;
    end
  end

  always_comb begin
    sNext = sReg;
    cNext = cReg;
    if (!freeze) begin
      if (cReg == LAST_SUB) begin
        cNext = '0;
        sNext = (sReg == LAST_STEP) ? '0 : sReg + 1'b1;
      end else begin
        cNext = cReg + 1'b1;
      end
    end
  end

  // Phase gi is high for steps gi .. 2*PHASES-2-gi, giving the symmetric staircase.
  for (genvar gi = 0; gi < PHASES; gi++) begin : gPhase
    localparam logic [SW-1:0] RISE_AT = SW'(gi);
    localparam logic [SW-1:0] FALL_AT = SW'(2 * PHASES - 1 - gi);
    if (gi == 0) begin : gFirst
      assign clkpNext[gi] = (sNext < FALL_AT);
    end else begin : gOther
      assign clkpNext[gi] = (sNext >= RISE_AT) && (sNext < FALL_AT);
    end
  end

  always_comb begin
    mclkNext = mclkReg;
    if (sNext == '0) begin
      mclkNext = 1'b0;
    end else if (sNext == TOP_STEP && cNext == MID_SUB) begin
      mclkNext = 1'b1;
    end
    instNext = (sNext == LAST_STEP);
  end

  assign bus.clkp     = clkpReg;
  assign bus.Mclk     = mclkReg;
  assign bus.instFlag = instReg;
endmodule

// File: tb/tb_bennett_clock.sv
// Directed bench for bennett_clock with PHASES=10, STEP_CYCLES=2 (edge 0 = first edge after reset release).
// Hold scenarios run only when BENNETT_HOLD_EN is defined.
module tb_bennett_clock;
  logic clk;
  logic reset;
  int   checks;
  int   fails;
  int   edgeCnt;

  bennett_clock_if #(.PHASES(10)) bus ();

  bennett_clock #(.PHASES(10), .STEP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edgeNo;
    logic [9:0] clkp;
    logic       mclk;
    logic       inst;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edgeCnt, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edgeCnt++;
  endtask

  task automatic tickTo(input int target);
    while (edgeCnt < target) tick();
  endtask

  task automatic checkOutputs(input string name, input logic [9:0] c, input logic m, input logic f);
    check({name, "_clkp"}, int'(bus.clkp), int'(c));
    check({name, "_Mclk"}, int'(bus.Mclk), int'(m));
    check({name, "_instFlag"}, int'(bus.instFlag), int'(f));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout edge=%0d", edgeCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] prevClkp;
    int         vi;
    int         riseCount;

    checks  = 0;
    fails   = 0;
    edgeCnt = -1;
`ifdef BENNETT_HOLD_EN
    bus.hold = 1'b0;
`endif
    vecs[0]  = '{0,  10'h001, 1'b0, 1'b0};
    vecs[1]  = '{1,  10'h001, 1'b0, 1'b0};
    vecs[2]  = '{3,  10'h003, 1'b0, 1'b0};
    vecs[3]  = '{4,  10'h007, 1'b0, 1'b0};
    vecs[4]  = '{12, 10'h07F, 1'b0, 1'b0};
    vecs[5]  = '{17, 10'h1FF, 1'b0, 1'b0};
    vecs[6]  = '{18, 10'h3FF, 1'b0, 1'b0};
    vecs[7]  = '{19, 10'h3FF, 1'b1, 1'b0};
    vecs[8]  = '{20, 10'h1FF, 1'b1, 1'b0};
    vecs[9]  = '{25, 10'h07F, 1'b1, 1'b0};
    vecs[10] = '{26, 10'h03F, 1'b1, 1'b0};
    vecs[11] = '{37, 10'h001, 1'b1, 1'b0};
    vecs[12] = '{38, 10'h000, 1'b1, 1'b1};
    vecs[13] = '{39, 10'h000, 1'b1, 1'b1};
    vecs[14] = '{40, 10'h001, 1'b0, 1'b0};
    vecs[15] = '{44, 10'h007, 1'b0, 1'b0};
    vecs[16] = '{79, 10'h000, 1'b1, 1'b1};

    // Reset held across several edges: outputs stay low.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutputs("reset_hold", 10'h000, 1'b0, 1'b0);

    @(negedge clk);
    reset   = 1'b0;
    edgeCnt = -1;

    // Three full Bennett cycles: table vectors, derived SRAM clock, step invariants, period.
    vi        = 0;
    riseCount = 0;
    prevClkp  = '0;
    for (int e = 0; e < 120; e++) begin
      tick();
      if (vi < NV && vecs[vi].edgeNo == edgeCnt) begin
        checkOutputs($sformatf("vec%0d", vi), vecs[vi].clkp, vecs[vi].mclk, vecs[vi].inst);
        vi++;
      end
      if (edgeCnt < 40)
        check("srclk", int'(bus.clkp[6] & ~bus.Mclk), (edgeCnt >= 12 && edgeCnt <= 18) ? 1 : 0);
      check("bit_changes", $countones(bus.clkp ^ prevClkp), (edgeCnt % 2 == 0) ? 1 : 0);
      if (bus.clkp[2] && !prevClkp[2]) begin
        check("clkp2_rise_edge", edgeCnt, 4 + 40 * riseCount);
        riseCount++;
      end
      prevClkp = bus.clkp;
    end
    check("vectors_applied", vi, NV);
    check("clkp2_rise_count", riseCount, 3);

    // Mid-cycle reset during s=13 of the fourth cycle.
    tickTo(146);
    checkOutputs("pre_reset_s13", 10'h03F, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutputs("async_reset", 10'h000, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutputs("reset_held_mid", 10'h000, 1'b0, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    edgeCnt = -1;
    tick();
    checkOutputs("restart_e0", 10'h001, 1'b0, 1'b0);
    tick();
    checkOutputs("restart_e1", 10'h001, 1'b0, 1'b0);
    tick();
    checkOutputs("restart_e2", 10'h003, 1'b0, 1'b0);

`ifdef BENNETT_HOLD_EN
    // Hold outside the top plateau is ignored.
    tickTo(6);
    bus.hold = 1'b1;
    tickTo(8);
    bus.hold = 1'b0;
    checkOutputs("hold_s3_ignored", 10'h01F, 1'b0, 1'b0);
    // Hold for 10 edges at the start of s=9 stretches the cycle to 50 clocks.
    tickTo(18);
    bus.hold = 1'b1;
    tickTo(28);
    checkOutputs("hold_frozen", 10'h3FF, 1'b0, 1'b0);
    bus.hold = 1'b0;
    tick();
    checkOutputs("hold_resume_mid", 10'h3FF, 1'b1, 1'b0);
    tick();
    checkOutputs("hold_resume_fall", 10'h1FF, 1'b1, 1'b0);
    tickTo(49);
    checkOutputs("hold_idle", 10'h000, 1'b1, 1'b1);
    tick();
    checkOutputs("hold_period50", 10'h001, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
